// File: rtl/rol_seq.sv
// ============================================================================
// Module   : rol_seq
// Purpose  : Sequential rotate unit, one bit position per clock, with
//            valid/ready handshakes on both sides. Optional ROL_DIR_EN macro
//            adds a per-request direction input (dir).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rol_seq #(
   parameter int WIDTH = 4,
   localparam int AW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AW-1:0]    amount,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             busy
`ifdef ROL_DIR_EN
   ,
   input  logic             dir
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [AW-1:0]    r_count;
   logic [WIDTH-1:0] r_data_out;
   logic [WIDTH-1:0] w_rot;

`ifdef ROL_DIR_EN
   logic r_dir;

   always_comb begin
      w_rot = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
      if (r_dir) begin
         w_rot = {r_shreg[0], r_shreg[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dir <= 1'b0;
      end else if (r_state == IDLE && in_valid) begin
         r_dir <= dir;
      end
   end
`else
   always_comb begin
      w_rot = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_nxt = (amount != '0) ? ROTATE : DONE;
            end
         end
         ROTATE: begin
            if (r_count == AW'(1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // data_out is captured only on entry to DONE so it holds between results
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         r_count    <= '0;
         r_data_out <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_shreg <= data_in;
                  r_count <= amount;
                  if (amount == '0) begin
                     r_data_out <= data_in;
                  end
               end
            end
            ROTATE: begin
               r_shreg <= w_rot;
               r_count <= r_count - AW'(1);
               if (r_count == AW'(1)) begin
                  r_data_out <= w_rot;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign data_out  = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_rol_seq.sv
// Self-checking bench for rol_seq: scoreboard of expected words, per-scenario tasks.
`default_nettype none

module tb_rol_seq;
   localparam int W  = 4;
   localparam int AW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  data_in;
   logic [AW-1:0] amount;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  data_out;
   logic          busy;
`ifdef ROL_DIR_EN
   logic          dir;
`endif

   int tests = 0;
   int fails = 0;
   logic [W-1:0] sb[$];

   always #5 clk = ~clk;

   rol_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .data_in  (data_in),
      .amount   (amount),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .data_out (data_out),
      .busy     (busy)
`ifdef ROL_DIR_EN
      ,
      .dir      (dir)
`endif
   );

   function automatic logic [W-1:0] rotl(input logic [W-1:0] d, input int a);
      logic [W-1:0] r;
      r = (d << a) | (d >> (W - a));
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request, push its expected result, return once accepted.
   task automatic drive_req(input logic [W-1:0] d, input int a, input logic [W-1:0] exp_w,
                            output bit ok);
      bit rdy;
      ok       = 1'b0;
      in_valid = 1'b1;
      data_in  = d;
      amount   = AW'(a);
      sb.push_back(exp_w);
      for (int i = 0; i < 50 && !ok; i++) begin
         rdy = in_ready;
         tick();
         ok = rdy;
      end
      in_valid = 1'b0;
   endtask

   // Cycles after the accepting edge until out_valid is seen.
   task automatic wait_out(output int cycles, output bit ok);
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         tick();
         cycles++;
      end
      ok = out_valid;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests++; if (data_out !== '0) begin fails++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
   endtask

   task automatic test_basic(input logic [W-1:0] d, input int a, input logic [W-1:0] lit);
      bit ok;
      int cyc;
      logic [W-1:0] e;
      drive_req(d, a, rotl(d, a), ok);
      wait_out(cyc, ok);
      tests++; if (!ok || cyc != a) begin fails++; $display("FAIL basic_latency d=%h a=%0d got=%0d exp=%0d", d, a, cyc, a); end
      e = sb.pop_front();
      tests++; if (data_out !== e) begin fails++; $display("FAIL basic_data d=%h a=%0d got=%h exp=%h", d, a, data_out, e); end
      tests++; if (data_out !== lit) begin fails++; $display("FAIL basic_literal d=%h a=%0d got=%h exp=%h", d, a, data_out, lit); end
      tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL basic_busy got=%b/%b exp=1/0", busy, in_ready); end
      consume();
   endtask

   task automatic test_backpressure();
      bit ok;
      int cyc;
      logic [W-1:0] e;
      drive_req(4'b0001, 3, 4'b1000, ok);
      wait_out(cyc, ok);
      tests++; if (!ok || cyc != 3) begin fails++; $display("FAIL bp_latency got=%0d exp=3", cyc); end
      e = sb.pop_front();
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (data_out !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold cyc=%0d got=%h/%b/%b exp=%h/1/0", i, data_out, out_valid, in_ready, e);
         end
         tick();
      end
      consume();
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got=%b/%b exp=1/0", in_ready, out_valid); end
      tests++; if (data_out !== e) begin fails++; $display("FAIL bp_data_kept got=%h exp=%h", data_out, e); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      drive_req(4'b0110, 3, rotl(4'b0110, 3), ok);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL midrst_state got=%b/%b/%b exp=1/0/0", in_ready, out_valid, busy);
      end
      tests++; if (data_out !== '0) begin fails++; $display("FAIL midrst_data got=%h exp=0", data_out); end
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale cyc=%0d got=%b exp=0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int cyc;
      logic [W-1:0] e;
      logic [W-1:0] mid;
      for (int d = 0; d < 16; d++) begin
         for (int a = 0; a < W; a++) begin
`ifdef ROL_DIR_EN
            dir = 1'b0;
`endif
            drive_req(W'(d), a, rotl(W'(d), a), ok);
            wait_out(cyc, ok);
            e = sb.pop_front();
            tests++; if (!ok || data_out !== e) begin fails++; $display("FAIL rt_fwd d=%0d a=%0d got=%h exp=%h", d, a, data_out, e); end
            mid = data_out;
            consume();
`ifdef ROL_DIR_EN
            dir = 1'b1;
            drive_req(mid, a, W'(d), ok);
`else
            drive_req(mid, (W - a) % W, W'(d), ok);
`endif
            wait_out(cyc, ok);
            e = sb.pop_front();
            tests++; if (!ok || data_out !== e) begin fails++; $display("FAIL rt_back d=%0d a=%0d got=%h exp=%h", d, a, data_out, e); end
            consume();
         end
      end
`ifdef ROL_DIR_EN
      dir = 1'b0;
`endif
   endtask

`ifdef ROL_DIR_EN
   task automatic test_dir();
      bit ok;
      int cyc;
      logic [W-1:0] e;
      dir = 1'b1;
      drive_req(4'b1011, 1, 4'b1101, ok);
      dir = 1'b0;
      wait_out(cyc, ok);
      tests++; if (!ok || cyc != 1) begin fails++; $display("FAIL dir_latency got=%0d exp=1", cyc); end
      e = sb.pop_front();
      tests++; if (data_out !== e) begin fails++; $display("FAIL dir_data got=%h exp=%h", data_out, e); end
      consume();
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      amount    = '0;
      out_ready = 1'b0;
`ifdef ROL_DIR_EN
      dir       = 1'b0;
`endif
      test_reset();
      test_basic(4'b1011, 1, 4'b0111);
      test_basic(4'b1001, 0, 4'b1001);
      test_basic(4'b1100, 2, 4'b0011);
      test_basic(4'b0001, 3, 4'b1000);
      test_backpressure();
      test_reset_mid();
`ifdef ROL_DIR_EN
      test_dir();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
